// File: rtl/crd_drop_pkg.sv
// Shared definitions for the sparse coordinate dropper: word layout, token
// helpers and the crddrop-mode state encoding.
package crd_drop_pkg;

    localparam int DATA_W = 17;
    localparam int TOKEN_BIT = 16;
    localparam logic [DATA_W-1:0] DONE_TOK = 17'h10100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_FLUSHOUT
    } crd_state_e;

    function automatic logic is_done(input logic [DATA_W-1:0] w);
        return w == DONE_TOK;
    endfunction

    // Stop tokens carry a zero middle byte; DONE is distinguished by 0x01 there.
    function automatic logic is_stop(input logic [DATA_W-1:0] w);
        return w[TOKEN_BIT] && (w[15:8] == 8'h00);
    endfunction

    function automatic logic [7:0] stop_lvl(input logic [DATA_W-1:0] w);
        return w[7:0];
    endfunction

    function automatic logic [DATA_W-1:0] make_stop(input logic [7:0] lvl);
        return {1'b1, 8'h00, lvl};
    endfunction

endpackage

// File: rtl/crd_drop_fifo.sv
// Small register-based FIFO used on every input and output port of crd_drop.
// Storage is cleared on reset/flush so an empty FIFO presents zero data.
module reg_fifo
    import crd_drop_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             clk_en,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clk_en) begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop) count <= count + CNT_W'(1);
            else if (!do_push && do_pop) count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/crd_drop.sv
// Sparse-stream coordinate dropper: mode 0 strips zero-valued pairs, mode 1
// drops outer coordinates whose inner fiber turned out to be empty.
module crd_drop
    import crd_drop_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              tile_en,
    input  logic              cmrg_enable,
    input  logic              cmrg_mode,
    input  logic [15:0]       cmrg_stop_lvl,
    input  logic [DATA_W-1:0] cmrg_coord_in_0,
    input  logic              cmrg_coord_in_0_valid,
    output logic              cmrg_coord_in_0_ready,
    input  logic [DATA_W-1:0] cmrg_coord_in_1,
    input  logic              cmrg_coord_in_1_valid,
    output logic              cmrg_coord_in_1_ready,
    output logic [DATA_W-1:0] cmrg_coord_out_0,
    output logic              cmrg_coord_out_0_valid,
    input  logic              cmrg_coord_out_0_ready,
    output logic [DATA_W-1:0] cmrg_coord_out_1,
    output logic              cmrg_coord_out_1_valid,
    input  logic              cmrg_coord_out_1_ready
);

    logic [DATA_W-1:0] in0_head, in1_head, push0_data, push1_data;
    logic              in0_full, in0_empty, in1_full, in1_empty;
    logic              out0_full, out0_empty, out1_full, out1_empty;
    logic              pop0, pop1, push0, push1, fire;
    crd_state_e        state, next_state;
    logic [DATA_W-1:0] outer_crd, next_outer;
    logic              has_data, next_has_data;
    logic              unused_cfg;

    assign unused_cfg = ^{cmrg_enable, cmrg_stop_lvl};

    assign cmrg_coord_in_0_ready  = !in0_full && tile_en;
    assign cmrg_coord_in_1_ready  = !in1_full && tile_en;
    assign cmrg_coord_out_0_valid = !out0_empty && tile_en;
    assign cmrg_coord_out_1_valid = !out1_empty && tile_en;

    reg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_in0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clk_en(clk_en),
        .push(cmrg_coord_in_0_valid && cmrg_coord_in_0_ready), .wdata(cmrg_coord_in_0),
        .pop(pop0), .rdata(in0_head), .full(in0_full), .empty(in0_empty));

    reg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_in1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clk_en(clk_en),
        .push(cmrg_coord_in_1_valid && cmrg_coord_in_1_ready), .wdata(cmrg_coord_in_1),
        .pop(pop1), .rdata(in1_head), .full(in1_full), .empty(in1_empty));

    reg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_out0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clk_en(clk_en),
        .push(push0), .wdata(push0_data),
        .pop(cmrg_coord_out_0_valid && cmrg_coord_out_0_ready),
        .rdata(cmrg_coord_out_0), .full(out0_full), .empty(out0_empty));

    reg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_out1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clk_en(clk_en),
        .push(push1), .wdata(push1_data),
        .pop(cmrg_coord_out_1_valid && cmrg_coord_out_1_ready),
        .rdata(cmrg_coord_out_1), .full(out1_full), .empty(out1_empty));

    // FLUSHOUT only writes DONE, so it may fire without any input heads present.
    assign fire = tile_en && !out0_full && !out1_full &&
                  ((!in0_empty && !in1_empty) || (cmrg_mode && state == ST_FLUSHOUT));

    always_comb begin
        pop0          = 1'b0;
        pop1          = 1'b0;
        push0         = 1'b0;
        push1         = 1'b0;
        push0_data    = in0_head;
        push1_data    = in1_head;
        next_state    = state;
        next_outer    = outer_crd;
        next_has_data = has_data;
        if (fire) begin
            if (!cmrg_mode) begin
                next_state = ST_IDLE;
                if (in0_head[TOKEN_BIT] == in1_head[TOKEN_BIT]) begin
                    pop0  = 1'b1;
                    pop1  = 1'b1;
                    push0 = in0_head[TOKEN_BIT] || (in0_head[15:0] != 16'h0);
                    push1 = in0_head[TOKEN_BIT] || (in0_head[15:0] != 16'h0);
                end else if (in0_head[TOKEN_BIT]) begin
                    pop1 = 1'b1;
                end else begin
                    pop0 = 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (is_done(in0_head) && is_done(in1_head)) begin
                            pop0       = 1'b1;
                            pop1       = 1'b1;
                            next_state = ST_FLUSHOUT;
                        end else if (!in0_head[TOKEN_BIT]) begin
                            pop0       = 1'b1;
                            next_outer = in0_head;
                            next_state = ST_HOLD;
                        end else if (is_stop(in0_head)) begin
                            pop0  = 1'b1;
                            push0 = 1'b1;
                        end else begin
                            pop1 = 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (!in1_head[TOKEN_BIT]) begin
                            pop1          = 1'b1;
                            push1         = 1'b1;
                            next_has_data = 1'b1;
                        end else if (is_stop(in1_head)) begin
                            pop1          = 1'b1;
                            next_state    = ST_IDLE;
                            next_has_data = 1'b0;
                            if (has_data) begin
                                push0      = 1'b1;
                                push0_data = outer_crd;
                                push1      = 1'b1;
                            end else if (stop_lvl(in1_head) != 8'd0) begin
                                // Empty fiber closing a higher level: demote the stop by one.
                                push1      = 1'b1;
                                push1_data = make_stop(stop_lvl(in1_head) - 8'd1);
                            end
                        end else begin
                            next_state = ST_IDLE;
                        end
                    end
                    ST_FLUSHOUT: begin
                        push0      = 1'b1;
                        push1      = 1'b1;
                        push0_data = DONE_TOK;
                        push1_data = DONE_TOK;
                        next_state = ST_IDLE;
                    end
                    default: next_state = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            outer_crd <= '0;
            has_data  <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            outer_crd <= '0;
            has_data  <= 1'b0;
        end else if (clk_en) begin
            state     <= next_state;
            outer_crd <= next_outer;
            has_data  <= next_has_data;
        end
    end

endmodule

// File: tb/tb_crd_drop.sv
// Self-checking bench for crd_drop: a queue-level stream model checked on every
// output transfer, plus literal expected streams for the directed scenarios.
module tb_crd_drop;

    localparam logic [16:0] S0   = 17'h10000;
    localparam logic [16:0] S1   = 17'h10001;
    localparam logic [16:0] DONE = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, flush, tile_en, cmrg_enable, cmrg_mode;
    logic [15:0] cmrg_stop_lvl;
    logic [16:0] in0_data, in1_data, out0_data, out1_data;
    logic        in0_valid, in1_valid, in0_ready, in1_ready;
    logic        out0_valid, out1_valid, out0_ready, out1_ready;

    int n_cmp  = 0;
    int n_err  = 0;
    int cycles = 0;
    bit check_en = 1'b0;
    bit throttle = 1'b0;

    logic [16:0] stim0[$], stim1[$], exp0_q[$], exp1_q[$];
    logic [16:0] got0_q[$], got1_q[$], lit0[$], lit1[$];

    crd_drop dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .cmrg_enable(cmrg_enable), .cmrg_mode(cmrg_mode), .cmrg_stop_lvl(cmrg_stop_lvl),
        .cmrg_coord_in_0(in0_data), .cmrg_coord_in_0_valid(in0_valid),
        .cmrg_coord_in_0_ready(in0_ready),
        .cmrg_coord_in_1(in1_data), .cmrg_coord_in_1_valid(in1_valid),
        .cmrg_coord_in_1_ready(in1_ready),
        .cmrg_coord_out_0(out0_data), .cmrg_coord_out_0_valid(out0_valid),
        .cmrg_coord_out_0_ready(out0_ready),
        .cmrg_coord_out_1(out1_data), .cmrg_coord_out_1_valid(out1_valid),
        .cmrg_coord_out_1_ready(out1_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycles++;
        if (cycles > 60000) begin
            $display("[TB] FAIL watchdog: ran %0d cycles, limit 60000", cycles);
            $fatal(1, "[TB] run aborted");
        end
    end

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Stream-level model: pair-wise filtering for mode 0, fiber grouping for mode 1.
    task automatic build_expected(input logic mode);
        int i = 0;
        int j = 0;
        logic [16:0] a, b, fib[$];
        exp0_q.delete();
        exp1_q.delete();
        if (!mode) begin
            while (i < stim0.size() && j < stim1.size()) begin
                a = stim0[i];
                b = stim1[j];
                if (a[16] == b[16]) begin
                    i++;
                    j++;
                    if (a[16] || a[15:0] != 16'h0) begin
                        exp0_q.push_back(a);
                        exp1_q.push_back(b);
                    end
                end else if (a[16]) j++;
                else i++;
            end
        end else begin
            while (i < stim0.size()) begin
                a = stim0[i];
                i++;
                if (a == DONE) begin
                    exp0_q.push_back(DONE);
                    exp1_q.push_back(DONE);
                    break;
                end
                if (a[16]) begin
                    exp0_q.push_back(a);
                    continue;
                end
                fib.delete();
                b = stim1[j];
                while (!b[16]) begin
                    fib.push_back(b);
                    j++;
                    b = stim1[j];
                end
                j++;
                if (fib.size() > 0) begin
                    exp0_q.push_back(a);
                    foreach (fib[k]) exp1_q.push_back(fib[k]);
                    exp1_q.push_back(b);
                end else if (b[7:0] != 8'd0) begin
                    exp1_q.push_back(b - 17'd1);
                end
            end
        end
    endtask

    task automatic drive0();
        int k = 0;
        bit acc;
        bit hold = 1'b0;
        while (k < stim0.size()) begin
            if (hold || !throttle || $urandom_range(0, 2) != 0) begin
                in0_valid = 1'b1;
                in0_data  = stim0[k];
            end else in0_valid = 1'b0;
            #1;
            acc = in0_valid && in0_ready;
            @(posedge clk);
            #1;
            hold = in0_valid && !acc;
            if (acc) k++;
        end
        in0_valid = 1'b0;
    endtask

    task automatic drive1();
        int k = 0;
        bit acc;
        bit hold = 1'b0;
        while (k < stim1.size()) begin
            if (hold || !throttle || $urandom_range(0, 2) != 0) begin
                in1_valid = 1'b1;
                in1_data  = stim1[k];
            end else in1_valid = 1'b0;
            #1;
            acc = in1_valid && in1_ready;
            @(posedge clk);
            #1;
            hold = in1_valid && !acc;
            if (acc) k++;
        end
        in1_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic mode);
        int w = 0;
        build_expected(mode);
        got0_q.delete();
        got1_q.delete();
        cmrg_mode = mode;
        check_en  = 1'b1;
        fork
            drive0();
            drive1();
        join
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 500) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL drain: %0d/%0d outputs outstanding, expected 0/0",
                     exp0_q.size(), exp1_q.size());
        end
        repeat (5) @(posedge clk);
        #3;
        throttle   = 1'b0;
        tile_en    = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        check_en   = 1'b0;
    endtask

    task automatic checkOutput(input string name);
        check({name, "_len0"}, 17'(got0_q.size()), 17'(lit0.size()));
        check({name, "_len1"}, 17'(got1_q.size()), 17'(lit1.size()));
        foreach (lit0[i]) check({name, "_out0"}, (i < got0_q.size()) ? got0_q[i] : 17'hx, lit0[i]);
        foreach (lit1[i]) check({name, "_out1"}, (i < got1_q.size()) ? got1_q[i] : 17'hx, lit1[i]);
    endtask

    task automatic load_scn(input int n);
        case (n)
            1: begin
                stim0 = '{17'd5, 17'd0, 17'd7, S0, DONE};
                stim1 = '{17'd1, 17'd2, 17'd3, S0, DONE};
                lit0  = '{17'd5, 17'd7, S0, DONE};
                lit1  = '{17'd1, 17'd3, S0, DONE};
            end
            2: begin
                stim0 = '{17'd0, 17'd0, S0, DONE};
                stim1 = '{17'd3, 17'd4, S0, DONE};
                lit0  = '{S0, DONE};
                lit1  = '{S0, DONE};
            end
            default: begin
                stim0 = '{17'd0, 17'd1, 17'd2, S0, DONE};
                stim1 = '{17'd4, S0, S0, 17'd6, 17'd7, S1, DONE};
                lit0  = '{17'd0, 17'd2, S0, DONE};
                lit1  = '{17'd4, S0, 17'd6, 17'd7, S1, DONE};
            end
        endcase
    endtask

    // Output throttling and tile_en toggling for the randomised passes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (throttle) begin
                out0_ready = ($urandom_range(0, 3) != 0);
                out1_ready = ($urandom_range(0, 3) != 0);
                tile_en    = ($urandom_range(0, 5) != 0);
            end
        end
    end

    // Scoreboard: every output transfer is checked against the model queues.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en && rst_n === 1'b1) begin
                if (out0_valid && out0_ready) begin
                    got0_q.push_back(out0_data);
                    if (exp0_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("[TB] FAIL out0_extra: got %h, expected no transfer", out0_data);
                    end else check("model_out0", out0_data, exp0_q.pop_front());
                end
                if (out1_valid && out1_ready) begin
                    got1_q.push_back(out1_data);
                    if (exp1_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("[TB] FAIL out1_extra: got %h, expected no transfer", out1_data);
                    end else check("model_out1", out1_data, exp1_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
        cmrg_enable = 1'b0; cmrg_mode = 1'b0; cmrg_stop_lvl = 16'h0;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        #2;
        check("rst_out0_valid", 17'(out0_valid), 17'd0);
        check("rst_out1_valid", 17'(out1_valid), 17'd0);
        check("rst_out0_data", out0_data, 17'd0);
        check("rst_out1_data", out1_data, 17'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_in0_ready", 17'(in0_ready), 17'd1);
        check("idle_in1_ready", 17'(in1_ready), 17'd1);
        @(posedge clk);
        #1;

        for (int n = 1; n <= 3; n++) begin
            load_scn(n);
            applyStimulus(n == 3);
            checkOutput($sformatf("scn%0d", n));
        end

        $display("[TB] throttled replay of scenarios 1-3");
        for (int n = 1; n <= 3; n++) begin
            load_scn(n);
            throttle = 1'b1;
            applyStimulus(n == 3);
            checkOutput($sformatf("thr%0d", n));
        end

        // Fill the output FIFOs, freeze with clk_en, then flush mid-stream.
        cmrg_mode = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
        stim0 = '{17'd5, 17'd0, 17'd7};
        stim1 = '{17'd1, 17'd2, 17'd3};
        fork
            drive0();
            drive1();
        join
        repeat (3) @(posedge clk);
        #1;
        check("fill_out0_valid", 17'(out0_valid), 17'd1);
        check("fill_out0_data", out0_data, 17'd5);
        clk_en = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clk_en = 1'b1; out0_ready = 1'b0; out1_ready = 1'b0;
        @(negedge clk);
        check("clken_out0_data", out0_data, 17'd5);
        check("clken_out1_data", out1_data, 17'd1);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_out0_valid", 17'(out0_valid), 17'd0);
        check("flush_out1_valid", 17'(out1_valid), 17'd0);
        check("flush_out0_data", out0_data, 17'd0);
        out0_ready = 1'b1; out1_ready = 1'b1;
        @(posedge clk);
        #1;
        load_scn(1);
        applyStimulus(1'b0);
        checkOutput("flush_replay");

        // Asynchronous reset mid-stream, then tile_en gating.
        out0_ready = 1'b0; out1_ready = 1'b0;
        stim0 = '{17'd5, 17'd0, 17'd7};
        stim1 = '{17'd1, 17'd2, 17'd3};
        fork
            drive0();
            drive1();
        join
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_out1_valid", 17'(out1_valid), 17'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out0_valid", 17'(out0_valid), 17'd0);
        check("arst_out1_valid", 17'(out1_valid), 17'd0);
        check("arst_out1_data", out1_data, 17'd0);
        @(posedge clk);
        #1 rst_n = 1'b1; tile_en = 1'b0;
        #1;
        check("tile_off_in0_ready", 17'(in0_ready), 17'd0);
        check("tile_off_in1_ready", 17'(in1_ready), 17'd0);
        @(posedge clk);
        #1 tile_en = 1'b1;
        #1;
        check("tile_on_in0_ready", 17'(in0_ready), 17'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
